// File: rtl/sp_ram_bist.sv
// -----------------------------------------------------------------------------
// sp_ram_bist
//
// March C- memory self-test engine for a single-port, 1-cycle-latency RAM.
// Word count N = RAM_SIZE/4. Elements, with 0 = BG_PATTERN and 1 = ~BG_PATTERN:
//   M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0);
//   M5 up(r0); then DRAIN (one idle cycle) and DONE.
// A fault-free run keeps busy_o high for 10N+1 cycles and leaves every word
// equal to BG_PATTERN. The first read mismatch stops the run at once and is
// reported through fail_o / fail_addr_o / fail_data_o.
//
// Ports
//   clk           rising-edge clock
//   rstn_i        asynchronous active-low reset (all outputs forced to 0)
//   start_i       one-cycle run request, accepted only in IDLE or DONE
//   busy_o        test in progress
//   done_o        test finished, sticky until the next accepted start
//   fail_o        mismatch seen (valid while done_o=1)
//   fail_addr_o   byte address of the first failing word
//   fail_data_o   read data captured at the first failure
//   mem_en_o      RAM enable
//   mem_we_o      RAM write enable
//   mem_addr_o    RAM byte address (word index << 2)
//   mem_wdata_o   RAM write data
//   mem_be_o      RAM byte enables, all ones while mem_en_o=1
//   mem_rdata_i   RAM read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module sp_ram_bist #(
    parameter int                    RAM_SIZE   = 32768,
    parameter int                    ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [ADDR_WIDTH-1:0]     fail_addr_o,
    output logic [DATA_WIDTH-1:0]     fail_data_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int N  = RAM_SIZE / 4;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] FIRST_IDX = '0;

    localparam logic [DATA_WIDTH-1:0] PAT0 = BG_PATTERN;
    localparam logic [DATA_WIDTH-1:0] PAT1 = ~BG_PATTERN;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_M0    = 4'd1;
    localparam logic [3:0] S_M1    = 4'd2;
    localparam logic [3:0] S_M2    = 4'd3;
    localparam logic [3:0] S_M3    = 4'd4;
    localparam logic [3:0] S_M4    = 4'd5;
    localparam logic [3:0] S_M5    = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]            state_reg,     state_next;
    logic [IW-1:0]         idx_reg,       idx_next;
    // In M1-M4: 0 = read cycle, 1 = write cycle of the same word.
    logic                  phase_reg,     phase_next;
    // M5 pipelining: the read issued last cycle is compared this cycle.
    logic                  rd_pend_reg,   rd_pend_next;
    logic [IW-1:0]         rd_idx_reg,    rd_idx_next;
    logic                  fail_reg,      fail_next;
    logic [ADDR_WIDTH-1:0] fail_addr_reg, fail_addr_next;
    logic [DATA_WIDTH-1:0] fail_data_reg, fail_data_next;

    // Value a read in the current element should return.
    logic [DATA_WIDTH-1:0] exp_rd;
    // Value written in the current element.
    logic [DATA_WIDTH-1:0] wr_pat;
    logic                  rw_elem;

    always_comb begin
        exp_rd  = PAT0;
        wr_pat  = PAT0;
        rw_elem = 1'b0;
        case (state_reg)
            S_M0: begin wr_pat = PAT0; end
            S_M1: begin exp_rd = PAT0; wr_pat = PAT1; rw_elem = 1'b1; end
            S_M2: begin exp_rd = PAT1; wr_pat = PAT0; rw_elem = 1'b1; end
            S_M3: begin exp_rd = PAT0; wr_pat = PAT1; rw_elem = 1'b1; end
            S_M4: begin exp_rd = PAT1; wr_pat = PAT0; rw_elem = 1'b1; end
            S_M5: begin exp_rd = PAT0; end
            default: begin end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        phase_next     = phase_reg;
        rd_pend_next   = 1'b0;
        rd_idx_next    = rd_idx_reg;
        fail_next      = fail_reg;
        fail_addr_next = fail_addr_reg;
        fail_data_next = fail_data_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_next     = S_M0;
                    idx_next       = FIRST_IDX;
                    phase_next     = 1'b0;
                    fail_next      = 1'b0;
                    fail_addr_next = '0;
                    fail_data_next = '0;
                end
            end

            S_M0: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = S_M1;
                    idx_next   = FIRST_IDX;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            S_M1, S_M2, S_M3, S_M4: begin
                if (!phase_reg) begin
                    phase_next = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    // Read data of this word arrives during its write cycle.
                    if (mem_rdata_i != exp_rd) begin
                        state_next     = S_DONE;
                        fail_next      = 1'b1;
                        fail_addr_next = {idx_reg, 2'b00};
                        fail_data_next = mem_rdata_i;
                    end else begin
                        case (state_reg)
                            S_M1: begin
                                if (idx_reg == LAST_IDX) begin
                                    state_next = S_M2;
                                    idx_next   = FIRST_IDX;
                                end else begin
                                    idx_next = idx_reg + 1'b1;
                                end
                            end
                            S_M2: begin
                                if (idx_reg == LAST_IDX) begin
                                    state_next = S_M3;
                                    idx_next   = LAST_IDX;
                                end else begin
                                    idx_next = idx_reg + 1'b1;
                                end
                            end
                            S_M3: begin
                                if (idx_reg == FIRST_IDX) begin
                                    state_next = S_M4;
                                    idx_next   = LAST_IDX;
                                end else begin
                                    idx_next = idx_reg - 1'b1;
                                end
                            end
                            default: begin
                                if (idx_reg == FIRST_IDX) begin
                                    state_next = S_M5;
                                    idx_next   = FIRST_IDX;
                                end else begin
                                    idx_next = idx_reg - 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            S_M5: begin
                rd_pend_next = 1'b1;
                rd_idx_next  = idx_reg;
                if (rd_pend_reg && (mem_rdata_i != exp_rd)) begin
                    state_next     = S_DONE;
                    rd_pend_next   = 1'b0;
                    fail_next      = 1'b1;
                    fail_addr_next = {rd_idx_reg, 2'b00};
                    fail_data_next = mem_rdata_i;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = S_DRAIN;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            S_DRAIN: begin
                // Only job left: compare the final M5 read.
                state_next = S_DONE;
                if (rd_pend_reg && (mem_rdata_i != PAT0)) begin
                    fail_next      = 1'b1;
                    fail_addr_next = {rd_idx_reg, 2'b00};
                    fail_data_next = mem_rdata_i;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            phase_reg     <= 1'b0;
            rd_pend_reg   <= 1'b0;
            rd_idx_reg    <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            phase_reg     <= phase_next;
            rd_pend_reg   <= rd_pend_next;
            rd_idx_reg    <= rd_idx_next;
            fail_reg      <= fail_next;
            fail_addr_reg <= fail_addr_next;
            fail_data_reg <= fail_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from reset-cleared registers, so every output drops
    // to 0 as soon as rstn_i goes low.
    // ------------------------------------------------------------------
    logic access_state;

    always_comb begin
        access_state = (state_reg == S_M0) || (state_reg == S_M1) ||
                       (state_reg == S_M2) || (state_reg == S_M3) ||
                       (state_reg == S_M4) || (state_reg == S_M5);
    end

    assign busy_o      = access_state || (state_reg == S_DRAIN);
    assign done_o      = (state_reg == S_DONE);
    assign fail_o      = fail_reg;
    assign fail_addr_o = fail_addr_reg;
    assign fail_data_o = fail_data_reg;

    assign mem_en_o    = access_state;
    assign mem_we_o    = (state_reg == S_M0) || (rw_elem && phase_reg);
    assign mem_addr_o  = mem_en_o ? {idx_reg, 2'b00} : '0;
    assign mem_wdata_o = mem_we_o ? wr_pat : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_be
            assign mem_be_o[gi] = mem_en_o;
        end
    endgenerate

endmodule
